ets_sweep_ctrl: RTL
===================

# ets_sweep_ctrl

Sweep controller that acts as the initiator for the equivalent-time-sampling accumulator's start/done handshake. For each delay-tap setting it loads the tap, waits a settle interval, raises `acc_start`, holds it until `acc_done`, captures the count, releases the handshake, and streams the result out on a ready/valid port. One tap setting produces one output beat. It sits between the configuration registers and the result FIFO/DMA, and drives the probe delay line.

## Interface
- `TAP_W`, 9: delay-tap index width.
- `DATA_W`, 32: accumulator count width.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_start` in 1: sweep request, sampled only in IDLE.
- `cfg_abort` in 1: abort request, level-sensitive.
- `cfg_num_taps` in TAP_W: number of taps to sweep (0..2^TAP_W-1), latched at start.
- `cfg_settle` in 8: settle cycles after each tap load, latched at start.
- `tap` out TAP_W: current delay-tap index, registered.
- `tap_load` out 1: one-cycle pulse when `tap` changes.
- `acc_start` out 1: accumulator start, level.
- `acc_done` in 1: accumulator done, level.
- `acc_data` in DATA_W: accumulator count, valid while `acc_done`=1.
- `m_tvalid` out 1, `m_tready` in 1, `m_tdata` out DATA_W, `m_tlast` out 1: result stream.
- `m_tuser` out TAP_W: tap index of the beat. Present only with `ETS_SWEEP_TAG_EN`.
- `busy` out 1: high whenever state≠IDLE.
- `sweep_done` out 1: one-cycle pulse at sweep completion.

## Operation
- All outputs are registered. Reset value of every output and of the internal index is 0. State resets to IDLE.
- States and transitions:
  - IDLE: on `cfg_start`, latch the config and set idx=0.
    - If `cfg_num_taps`==0, pulse `sweep_done` and stay in IDLE.
    - Otherwise go to SET_TAP.
  - SET_TAP: `tap`<=idx and `tap_load`=1 for one cycle. Load the settle counter with `cfg_settle`, then go to SETTLE.
  - SETTLE: decrement the settle counter. When it is 0, go to RUN. `cfg_settle`=0 means no extra cycles.
  - RUN: `acc_start`=1, held until `acc_done`=1 is sampled. On that edge: result<=`acc_data`, `acc_start`<=0, go to DRAIN.
  - DRAIN: wait for `acc_done`=0, then go to EMIT.
  - EMIT: `m_tvalid`=1, `m_tdata`=result, `m_tlast`=(idx==num_taps-1). On `m_tvalid`&`m_tready`:
    - If last: pulse `sweep_done` and go to IDLE.
    - Else: idx<=idx+1 and go to SET_TAP.
  - ABORT: `acc_start`=0. Wait for `acc_done`=0, then go to IDLE. No beat is emitted and `sweep_done` is not pulsed.
- `cfg_abort` is honoured in SET_TAP, SETTLE, RUN and DRAIN; these go to ABORT on the next edge.
- `cfg_abort` is ignored in EMIT, so a valid beat is never withdrawn. It takes effect at the next SET_TAP.
- If `cfg_abort` and `acc_done` are sampled high together in RUN, abort wins and `acc_data` is discarded.
- `cfg_start` is ignored when state≠IDLE.
- Config inputs may change mid-sweep without effect, because the latched copies are used.
- idx never wraps: the maximum idx is `cfg_num_taps`-1.

## Timing
- Edge E samples `cfg_start`. `tap_load` is high in cycle E+1.
- `acc_start` rises at E+3+`cfg_settle` (SET_TAP, the SETTLE exit cycle, then `cfg_settle` wait cycles).
- `acc_start` falls on the edge after `acc_done` is first sampled high.
- `m_tvalid` rises one cycle after `acc_done` is sampled low in DRAIN.
- The next `tap_load` occurs one cycle after the accepting handshake.
- `m_tdata`, `m_tlast` and `m_tuser` are stable while `m_tvalid`=1 and `m_tready`=0.
- `rst_n`=0 at any edge forces every output to 0 at that edge, including mid-handshake. The accumulator sees `acc_start` drop and recovers through its own CLR path.

## Configuration
- `ETS_SWEEP_TAG_EN` defined: the `m_tuser` port exists and carries the latched idx of each beat, with the same timing as `m_tdata`.
- Not defined: the port and its register are absent, and the beat carries only the count.

## Test plan
- Basic sweep: `cfg_num_taps`=3, `cfg_settle`=2, tready=1. The accumulator model asserts done 10 cycles after start with data=100+tap.
  - Required: taps 0,1,2, one `tap_load` each, and beats 100,101,102.
  - `m_tlast` is set only on 102, and there is a single `sweep_done` pulse.
- Backpressure: hold `m_tready`=0 for 5 cycles during EMIT.
  - Required: `m_tdata` and `m_tlast` stay stable and no `tap_load` occurs until acceptance.
  - The next `tap_load` occurs exactly one cycle after the handshake.
- Zero taps: `cfg_num_taps`=0.
  - Required: a `sweep_done` pulse at E+1, and `acc_start`, `m_tvalid` and `busy` never assert.
- Abort in RUN: assert `cfg_abort` with `acc_done` held high 3 more cycles.
  - Required: `acc_start` drops next edge, the design waits in ABORT, then IDLE, with no beat and no `sweep_done`.
  - Repeat with abort and done simultaneous; no beat is emitted.
- Reset mid-sweep: drive `rst_n`=0 during RUN at tap 1.
  - Required: all outputs are 0 on the following cycle and `tap`=0.
  - A new `cfg_start` restarts from tap 0.
- `ETS_SWEEP_TAG_EN` build, 4 taps with random backpressure.
  - Required: `m_tuser`=0,1,2,3, matching each beat.

Source files
------------

// File: rtl/ets_sweep_if.sv
// Sweep controller bus: probe delay-line drive, accumulator start/done handshake
// and result stream. m_tuser exists only when ETS_SWEEP_TAG_EN is defined.
interface ets_sweep_if #(
  parameter int TAP_W  = 9,
  parameter int DATA_W = 32
);
  logic [TAP_W-1:0]  tap;
  logic              tap_load;
  logic              acc_start;
  logic              acc_done;
  logic [DATA_W-1:0] acc_data;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
`ifdef ETS_SWEEP_TAG_EN
  logic [TAP_W-1:0]  m_tuser;

  modport master (
    output tap, tap_load, acc_start, m_tvalid, m_tdata, m_tlast, m_tuser,
    input  acc_done, acc_data, m_tready
  );
  modport slave (
    input  tap, tap_load, acc_start, m_tvalid, m_tdata, m_tlast, m_tuser,
    output acc_done, acc_data, m_tready
  );
`else
  modport master (
    output tap, tap_load, acc_start, m_tvalid, m_tdata, m_tlast,
    input  acc_done, acc_data, m_tready
  );
  modport slave (
    input  tap, tap_load, acc_start, m_tvalid, m_tdata, m_tlast,
    output acc_done, acc_data, m_tready
  );
`endif
endinterface

// File: rtl/ets_sweep_ctrl.sv
// ETS sweep controller: per tap, load the delay line, settle, run one accumulator
// start/done handshake and stream the count. Define ETS_SWEEP_TAG_EN to add m_tuser.
module ets_sweep_ctrl #(
  parameter int TAP_W  = 9,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [TAP_W-1:0] cfg_num_taps,
  input  logic [7:0]       cfg_settle,
  output logic             busy,
  output logic             sweep_done,
  ets_sweep_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET_TAP, S_SETTLE, S_RUN, S_DRAIN, S_EMIT, S_ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  idx_q, idx_d;
  logic [TAP_W-1:0]  num_q, num_d;
  logic [7:0]        settle_q, settle_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              tap_load_q, tap_load_d;
  logic              acc_start_q, acc_start_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
`ifdef ETS_SWEEP_TAG_EN
  logic [TAP_W-1:0]  m_tuser_q, m_tuser_d;
`endif

  logic hs;
  logic last_idx;

  assign hs       = m_tvalid_q & bus.m_tready;
  assign last_idx = (idx_q == num_q - TAP_W'(1));

  // State register plus every registered output and latched config copy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      tap_q        <= '0;
      tap_load_q   <= 1'b0;
      acc_start_q  <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
`ifdef ETS_SWEEP_TAG_EN
      m_tuser_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      tap_load_q   <= tap_load_d;
      acc_start_q  <= acc_start_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
`ifdef ETS_SWEEP_TAG_EN
      m_tuser_q    <= m_tuser_d;
`endif
    end
  end

  // Next state; abort is checked before acc_done so a simultaneous done is dropped
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          num_d    = cfg_num_taps;
          settle_d = cfg_settle;
          idx_d    = '0;
          if (cfg_num_taps != '0) begin
            state_d = S_SET_TAP;
          end
        end
      end
      S_SET_TAP: begin
        if (cfg_abort) begin
          state_d = S_ABORT;
        end else begin
          cnt_d   = settle_q;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cfg_abort) begin
          state_d = S_ABORT;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RUN: begin
        if (cfg_abort) begin
          state_d = S_ABORT;
        end else if (bus.acc_done) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cfg_abort) begin
          state_d = S_ABORT;
        end else if (!bus.acc_done) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (last_idx) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + TAP_W'(1);
            state_d = S_SET_TAP;
          end
        end
      end
      S_ABORT: begin
        if (!bus.acc_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they are registered alongside it
  always_comb begin
    tap_d        = tap_q;
    tap_load_d   = 1'b0;
    acc_start_d  = (state_d == S_RUN);
    m_tvalid_d   = (state_d == S_EMIT);
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = (state_d == S_EMIT) ? last_idx : 1'b0;
    busy_d       = (state_d != S_IDLE);
    sweep_done_d = 1'b0;
`ifdef ETS_SWEEP_TAG_EN
    m_tuser_d    = (state_d == S_EMIT) ? idx_q : m_tuser_q;
`endif
    if (state_d == S_SET_TAP) begin
      tap_d      = idx_d;
      tap_load_d = 1'b1;
    end
    if (state_q == S_RUN && state_d == S_DRAIN) begin
      m_tdata_d = bus.acc_data;
    end
    if (state_q == S_IDLE && cfg_start && cfg_num_taps == '0) begin
      sweep_done_d = 1'b1;
    end
    if (state_q == S_EMIT && hs && last_idx) begin
      sweep_done_d = 1'b1;
    end
  end

  assign bus.tap       = tap_q;
  assign bus.tap_load  = tap_load_q;
  assign bus.acc_start = acc_start_q;
  assign bus.m_tvalid  = m_tvalid_q;
  assign bus.m_tdata   = m_tdata_q;
  assign bus.m_tlast   = m_tlast_q;
`ifdef ETS_SWEEP_TAG_EN
  assign bus.m_tuser   = m_tuser_q;
`endif
  assign busy          = busy_q;
  assign sweep_done    = sweep_done_q;

  // A presented beat never changes or disappears until it is accepted
  a_beat_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_tvalid_q && !bus.m_tready) |=>
      (m_tvalid_q && $stable(m_tdata_q) && $stable(m_tlast_q)));

  a_tap_load_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    tap_load_q |=> !tap_load_q);

  a_start_vs_beat: assert property (@(posedge clk) disable iff (!rst_n)
    !(acc_start_q && m_tvalid_q));

  a_idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != S_IDLE) |-> (idx_q < num_q));

endmodule
